// File: rtl/soda_pkg.sv
// soda_pkg: coin encodings, coin values in nickel units and FSM state codes
package soda_pkg;
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_N    = 2'b01;
  localparam logic [1:0] COIN_D    = 2'b10;
  localparam logic [1:0] COIN_Q    = 2'b11;
  localparam logic [2:0] VAL_Q = 3'd5;
  localparam logic [2:0] VAL_D = 3'd2;
  localparam logic [2:0] VAL_N = 3'd1;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SELECT = 2'd1;
  localparam logic [1:0] ST_ISSUE  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;
  function automatic logic [2:0] coin_value(input logic [1:0] c);
    return c == COIN_Q ? VAL_Q : c == COIN_D ? VAL_D : c == COIN_N ? VAL_N : 3'd0;
  endfunction
endpackage

// File: rtl/coin_inventory.sv
// coin_inventory: quarter/dime/nickel stock down-counters with refill load and empty flags
module coin_inventory #(
  parameter int unsigned INV_W  = 4,
  parameter int unsigned INIT_Q = 8,
  parameter int unsigned INIT_D = 8,
  parameter int unsigned INIT_N = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       refill,
  input  logic [2:0] dec,
  output logic       q_empty,
  output logic       d_empty,
  output logic       n_empty
);
  logic [INV_W-1:0] q_cnt_q, q_cnt_d, d_cnt_q, d_cnt_d, n_cnt_q, n_cnt_d;
  // dec is one-hot {Q,D,N}; callers only decrement a non-empty counter
  always_comb begin
    q_cnt_d = refill ? INV_W'(INIT_Q) : q_cnt_q - INV_W'(dec[2]);
    d_cnt_d = refill ? INV_W'(INIT_D) : d_cnt_q - INV_W'(dec[1]);
    n_cnt_d = refill ? INV_W'(INIT_N) : n_cnt_q - INV_W'(dec[0]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_cnt_q <= INV_W'(INIT_Q);
      d_cnt_q <= INV_W'(INIT_D);
      n_cnt_q <= INV_W'(INIT_N);
    end else begin
      q_cnt_q <= q_cnt_d;
      d_cnt_q <= d_cnt_d;
      n_cnt_q <= n_cnt_d;
    end
  end
  assign q_empty = q_cnt_q == '0;
  assign d_empty = d_cnt_q == '0;
  assign n_empty = n_cnt_q == '0;
endmodule

// File: rtl/soda_change_dispenser.sv
// soda_change_dispenser: pays a change request out one coin at a time, greedy Q > D > N
module soda_change_dispenser
  import soda_pkg::*;
#(
  parameter int unsigned AMT_W       = 6,
  parameter int unsigned INV_W       = 4,
  parameter int unsigned INIT_Q      = 8,
  parameter int unsigned INIT_D      = 8,
  parameter int unsigned INIT_N      = 8,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amt,
  output logic             req_ready,
  output logic             coin_valid,
  output logic [1:0]       coin_type,
  input  logic             coin_ack,
  input  logic             refill,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] remain,
  output logic             busy
);
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  logic [1:0]       state_q, state_d, coin_type_q, coin_type_d, pick;
  logic [AMT_W-1:0] rem_q, rem_d, remain_q, remain_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             coin_valid_q, coin_valid_d, done_q, done_d, short_q, short_d;
  logic             q_empty, d_empty, n_empty;
  logic [2:0]       dec;
  coin_inventory #(
    .INV_W (INV_W),
    .INIT_Q(INIT_Q),
    .INIT_D(INIT_D),
    .INIT_N(INIT_N)
  ) u_inv (
    .clk    (clk),
    .rst_n  (rst_n),
    .refill (refill && state_q == ST_IDLE),
    .dec    (dec),
    .q_empty(q_empty),
    .d_empty(d_empty),
    .n_empty(n_empty)
  );
  // greedy pick with no backtracking: a short result can leave payable change unpaid
  assign pick = (!q_empty && rem_q >= AMT_W'(VAL_Q)) ? COIN_Q :
                (!d_empty && rem_q >= AMT_W'(VAL_D)) ? COIN_D :
                (!n_empty && rem_q != '0)            ? COIN_N : COIN_NONE;
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    coin_type_d  = coin_type_q;
    coin_valid_d = coin_valid_q;
    done_d       = 1'b0;
    short_d      = short_q;
    remain_d     = remain_q;
    tmo_d        = tmo_q;
    dec          = 3'b000;
    case (state_q)
      ST_IDLE: if (req_valid) begin
        rem_d    = req_amt;
        short_d  = 1'b0;
        remain_d = '0;
        state_d  = req_amt == '0 ? ST_DONE : ST_SELECT;
        done_d   = req_amt == '0;
      end
      ST_SELECT: begin
        state_d      = pick == COIN_NONE ? ST_DONE : ST_ISSUE;
        done_d       = pick == COIN_NONE;
        short_d      = pick == COIN_NONE && rem_q != '0;
        remain_d     = pick == COIN_NONE ? rem_q : remain_q;
        coin_type_d  = pick;
        coin_valid_d = pick != COIN_NONE;
        tmo_d        = '0;
      end
      ST_ISSUE: if (coin_ack) begin
        rem_d        = rem_q - AMT_W'(coin_value(coin_type_q));
        dec          = {coin_type_q == COIN_Q, coin_type_q == COIN_D, coin_type_q == COIN_N};
        coin_valid_d = 1'b0;
        coin_type_d  = COIN_NONE;
        state_d      = ST_SELECT;
      end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
        coin_valid_d = 1'b0;
        coin_type_d  = COIN_NONE;
        state_d      = ST_DONE;
        done_d       = 1'b1;
        short_d      = 1'b1;
        remain_d     = rem_q;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rem_q        <= '0;
      coin_type_q  <= COIN_NONE;
      coin_valid_q <= 1'b0;
      done_q       <= 1'b0;
      short_q      <= 1'b0;
      remain_q     <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      coin_type_q  <= coin_type_d;
      coin_valid_q <= coin_valid_d;
      done_q       <= done_d;
      short_q      <= short_d;
      remain_q     <= remain_d;
      tmo_q        <= tmo_d;
    end
  end
  assign req_ready  = state_q == ST_IDLE;
  assign busy       = state_q != ST_IDLE;
  assign coin_valid = coin_valid_q;
  assign coin_type  = coin_type_q;
  assign done       = done_q;
  assign short      = short_q;
  assign remain     = remain_q;
endmodule

// File: tb/tb_soda_change_dispenser.sv
// tb_soda_change_dispenser: table vectors, corner sequences and a greedy-payout reference model
module tb_soda_change_dispenser;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic req_valid = 1'b0, coin_ack = 1'b0, refill = 1'b0;
  logic [5:0] req_amt = '0, remain;
  logic req_ready, coin_valid, done, short, busy;
  logic [1:0] coin_type;
  logic v3 = 1'b0, ack3 = 1'b0, rf3 = 1'b0;
  logic [5:0] amt3 = '0, rm3;
  logic rdy3, cv3, dn3, sh3, busy3;
  logic [1:0] ct3;
  soda_change_dispenser dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_amt(req_amt), .req_ready(req_ready),
    .coin_valid(coin_valid), .coin_type(coin_type), .coin_ack(coin_ack), .refill(refill),
    .done(done), .short(short), .remain(remain), .busy(busy)
  );
  soda_change_dispenser #(.INIT_Q(0), .INIT_D(1), .INIT_N(0)) d3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_amt(amt3), .req_ready(rdy3),
    .coin_valid(cv3), .coin_type(ct3), .coin_ack(ack3), .refill(rf3),
    .done(dn3), .short(sh3), .remain(rm3), .busy(busy3)
  );
  int n_vec = 0, n_err = 0;
  int fix_dly = -1, last_vcnt = 0;
  int mq = 8, md = 8, mn = 8;
  logic [1:0] got[$];
  logic [1:0] exp_q[$];
  typedef struct {
    logic [5:0] amt;
    bit         rf;
    int         nq, nd, nn;
    bit         sh;
    int         rm;
  } vec_t;
  vec_t tbl[8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic chk_stock(input string name, input int q, input int d, input int n);
    chk({name, "_q"}, 32'(dut.u_inv.q_cnt_q), q);
    chk({name, "_d"}, 32'(dut.u_inv.d_cnt_q), d);
    chk({name, "_n"}, 32'(dut.u_inv.n_cnt_q), n);
  endtask
  function automatic int cnt(input logic [1:0] c);
    int k = 0;
    foreach (got[i]) if (got[i] == c) k++;
    return k;
  endfunction
  task automatic next;
    @(posedge clk);
    #1;
  endtask
  // acts as the coin mechanism; no_ack names the coin index that is never acknowledged
  task automatic pay(input logic [5:0] amt, input bit rf, input int no_ack, output bit sh, output logic [5:0] rm);
    int vcnt = 0, idx = 0, dly = 0, cyc = 0;
    bit fin = 0;
    sh = 0;
    rm = '0;
    got.delete();
    chk("ready_before_req", req_ready, 1);
    req_valid = 1'b1;
    req_amt = amt;
    refill = rf;
    next();
    req_valid = 1'b0;
    refill = 1'b0;
    while (!fin && cyc < 400) begin
      if (done) begin
        sh = short;
        rm = remain;
        fin = 1;
      end else if (coin_valid) begin
        if (vcnt == 0) begin
          got.push_back(coin_type);
          dly = fix_dly >= 0 ? fix_dly : int'($urandom_range(0, 3));
        end
        vcnt++;
        last_vcnt = vcnt;
        coin_ack = (idx != no_ack) && vcnt > dly;
      end else begin
        if (vcnt != 0) idx++;
        vcnt = 0;
        coin_ack = 1'b0;
      end
      if (!fin) begin
        next();
        cyc++;
      end
    end
    coin_ack = 1'b0;
    if (!fin) begin
      n_vec++;
      n_err++;
      $display("FAIL pay_timeout: got no done within 400 cycles for amt %0d", amt);
    end
    next();
    chk("done_one_cycle", done, 0);
    chk("ready_after_done", req_ready, 1);
  endtask
  task automatic model(input int amt, input bit rf, input int no_ack, output bit sh, output int rm);
    int rem = amt, idx = 0, c = 0;
    if (rf) begin mq = 8; md = 8; mn = 8; end
    exp_q.delete();
    sh = 0;
    while (rem > 0) begin
      if (rem >= 5 && mq > 0) c = 3;
      else if (rem >= 2 && md > 0) c = 2;
      else if (mn > 0) c = 1;
      else begin sh = 1; break; end
      exp_q.push_back(2'(c));
      if (idx == no_ack) begin sh = 1; break; end
      rem -= c == 3 ? 5 : c == 2 ? 2 : 1;
      if (c == 3) mq--; else if (c == 2) md--; else mn--;
      idx++;
    end
    rm = rem;
  endtask
  initial begin
    bit sh, msh;
    logic [5:0] rm;
    int mrm, k;
    tbl[0] = '{6'd8,  1'b1, 1, 1, 1, 1'b0, 0};
    tbl[1] = '{6'd0,  1'b1, 0, 0, 0, 1'b0, 0};
    tbl[2] = '{6'd1,  1'b1, 0, 0, 1, 1'b0, 0};
    tbl[3] = '{6'd4,  1'b1, 0, 2, 0, 1'b0, 0};
    tbl[4] = '{6'd7,  1'b1, 1, 1, 0, 1'b0, 0};
    tbl[5] = '{6'd63, 1'b1, 8, 8, 7, 1'b0, 0};
    tbl[6] = '{6'd10, 1'b0, 0, 0, 1, 1'b1, 9};
    tbl[7] = '{6'd6,  1'b1, 1, 0, 1, 1'b0, 0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_coin_valid", coin_valid, 0);
    chk("rst_coin_type", coin_type, 0);
    chk("rst_done", done, 0);
    chk("rst_short", short, 0);
    chk("rst_remain", remain, 0);
    chk_stock("rst_stock", 8, 8, 8);
    rst_n = 1'b1;
    // 40c with fixed ack delay: quarter, dime, nickel
    fix_dly = 2;
    pay(6'd8, 1'b0, -1, sh, rm);
    chk("t1_ncoins", got.size(), 3);
    if (got.size() == 3) begin
      chk("t1_c0", got[0], 3);
      chk("t1_c1", got[1], 2);
      chk("t1_c2", got[2], 1);
    end
    chk("t1_short", sh, 0);
    chk("t1_remain", rm, 0);
    chk_stock("t1_stock", 7, 7, 7);
    fix_dly = -1;
    // latency: accept in cycle 0, coin_valid in cycle 2, done two cycles after final ack
    req_valid = 1'b1;
    req_amt = 6'd1;
    next();
    req_valid = 1'b0;
    chk("lat_c1_valid", coin_valid, 0);
    chk("lat_c1_busy", busy, 1);
    chk("lat_c1_ready", req_ready, 0);
    next();
    chk("lat_c2_valid", coin_valid, 1);
    chk("lat_c2_type", coin_type, 1);
    coin_ack = 1'b1;
    next();
    coin_ack = 1'b0;
    chk("lat_c3_valid", coin_valid, 0);
    chk("lat_c3_type", coin_type, 0);
    chk("lat_c3_done", done, 0);
    next();
    chk("lat_c4_done", done, 1);
    chk("lat_c4_short", short, 0);
    next();
    chk("lat_c5_done", done, 0);
    chk_stock("lat_stock", 7, 7, 6);
    // zero request
    req_valid = 1'b1;
    req_amt = 6'd0;
    next();
    req_valid = 1'b0;
    chk("t2_done", done, 1);
    chk("t2_valid", coin_valid, 0);
    chk("t2_short", short, 0);
    next();
    chk("t2_done_low", done, 0);
    chk("t2_busy", busy, 0);
    // never acknowledged: jam timeout
    pay(6'd5, 1'b0, 0, sh, rm);
    chk("t4_valid_cycles", last_vcnt, 16);
    chk("t4_short", sh, 1);
    chk("t4_remain", rm, 5);
    chk_stock("t4_stock", 7, 7, 6);
    // refill and new requests while busy are ignored
    req_valid = 1'b1;
    req_amt = 6'd5;
    next();
    req_amt = 6'd9;
    refill = 1'b1;
    chk("t6_ready_c1", req_ready, 0);
    next();
    chk("t6_ready_c2", req_ready, 0);
    chk("t6_valid_c2", coin_valid, 1);
    next();
    chk("t6_valid_c3", coin_valid, 1);
    coin_ack = 1'b1;
    next();
    coin_ack = 1'b0;
    chk("t6_ready_c4", req_ready, 0);
    next();
    req_valid = 1'b0;
    refill = 1'b0;
    chk("t6_done", done, 1);
    chk("t6_remain", remain, 0);
    next();
    chk("t6_busy_after", busy, 0);
    chk_stock("t6_stock_kept", 6, 7, 6);
    refill = 1'b1;
    next();
    refill = 1'b0;
    chk_stock("t6_stock_refill", 8, 8, 8);
    // reset mid-payout
    pay(6'd8, 1'b0, -1, sh, rm);
    req_valid = 1'b1;
    req_amt = 6'd5;
    next();
    req_valid = 1'b0;
    next();
    chk("t5_valid_before", coin_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid_async", coin_valid, 0);
    chk("t5_busy_async", busy, 0);
    next();
    rst_n = 1'b1;
    chk("t5_ready", req_ready, 1);
    chk_stock("t5_stock", 8, 8, 8);
    // small inventory instance: one dime then short by one nickel
    v3 = 1'b1;
    amt3 = 6'd3;
    next();
    v3 = 1'b0;
    k = 0;
    while (!cv3 && k < 10) begin next(); k++; end
    chk("t3_valid", cv3, 1);
    chk("t3_type", ct3, 2);
    ack3 = 1'b1;
    next();
    ack3 = 1'b0;
    k = 0;
    while (!dn3 && k < 10) begin
      if (cv3) begin n_vec++; n_err++; $display("FAIL t3_extra_coin: got coin_valid 1 expected 0"); end
      next();
      k++;
    end
    chk("t3_done", dn3, 1);
    chk("t3_short", sh3, 1);
    chk("t3_remain", rm3, 1);
    // table vectors
    foreach (tbl[i]) begin
      pay(tbl[i].amt, tbl[i].rf, -1, sh, rm);
      chk($sformatf("tbl%0d_nq", i), cnt(2'b11), tbl[i].nq);
      chk($sformatf("tbl%0d_nd", i), cnt(2'b10), tbl[i].nd);
      chk($sformatf("tbl%0d_nn", i), cnt(2'b01), tbl[i].nn);
      chk($sformatf("tbl%0d_short", i), sh, tbl[i].sh);
      chk($sformatf("tbl%0d_remain", i), rm, tbl[i].rm);
    end
    // randomized against the model
    for (int t = 0; t < 40; t++) begin
      int amt, na;
      bit rf;
      amt = int'($urandom_range(0, 63));
      rf = t == 0 || $urandom_range(0, 3) == 0;
      na = $urandom_range(0, 7) == 0 ? int'($urandom_range(0, 3)) : -1;
      model(amt, rf, na, msh, mrm);
      pay(6'(amt), rf, na, sh, rm);
      chk($sformatf("rnd%0d_ncoins", t), got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
        chk($sformatf("rnd%0d_coin%0d", t, i), got[i], exp_q[i]);
      chk($sformatf("rnd%0d_short", t), sh, msh);
      chk($sformatf("rnd%0d_remain", t), rm, mrm);
      chk_stock($sformatf("rnd%0d_stock", t), mq, md, mn);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
